// File: rtl/bavg_multi.sv
// N-input stochastic-bitstream averager: adds popcount(x) into a residue accumulator and emits a 1 per N input ones.
// Optional density window counter is enabled by defining BAVG_WINDOW_EN.
module bavg_multi #(
    parameter int N       = 4,
    parameter int PRELOAD = 0,
    parameter int WIN_LEN = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic                           clr,
    input  logic [N-1:0]                   x,
    output logic                           y,
    output logic                           y_valid,
    output logic [$clog2(WIN_LEN+1)-1:0]   win_count,
    output logic                           win_done
);
    localparam int AW = $clog2(N);
    localparam int SW = $clog2(2 * N);
    localparam int CW = $clog2(WIN_LEN + 1);

    logic [AW-1:0] acc;
    logic [AW-1:0] acc_next;
    logic [SW-1:0] s;
    logic [SW-1:0] t;
    logic          y_next;

    // t never exceeds 2N-1, so a single conditional subtract keeps acc < N
    always_comb begin
        s = '0;
        for (int i = 0; i < N; i++) begin
            s = s + SW'(x[i]);
        end
        t        = SW'(acc) + s;
        y_next   = (t >= SW'(N));
        acc_next = y_next ? AW'(t - SW'(N)) : AW'(t);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= AW'(PRELOAD);
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else if (clr) begin
            acc     <= AW'(PRELOAD);
            y       <= 1'b0;
            y_valid <= 1'b0;
        end else if (en) begin
            acc     <= acc_next;
            y       <= y_next;
            y_valid <= 1'b1;
        end else begin
            y       <= 1'b0;
            y_valid <= 1'b0;
        end
    end

`ifdef BAVG_WINDOW_EN
    localparam int YW = $clog2(WIN_LEN);

    logic [YW-1:0] cyc;
    logic [CW-1:0] ones;

    // The closing edge folds its own y bit into win_count so no sample straddles windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc       <= '0;
            ones      <= '0;
            win_count <= '0;
            win_done  <= 1'b0;
        end else if (clr) begin
            cyc      <= '0;
            ones     <= '0;
            win_done <= 1'b0;
        end else if (en) begin
            if (cyc == YW'(WIN_LEN - 1)) begin
                win_count <= ones + CW'(y_next);
                win_done  <= 1'b1;
                cyc       <= '0;
                ones      <= '0;
            end else begin
                win_done <= 1'b0;
                cyc      <= cyc + YW'(1);
                ones     <= ones + CW'(y_next);
            end
        end else begin
            win_done <= 1'b0;
        end
    end
`else
    assign win_count = '0;
    assign win_done  = 1'b0;
`endif

endmodule
